kernel_memory: RTL and testbench

- Single-port-write / single-port-read kernel weight buffer for the CNN coprocessor.
- Stores MEM_DEPTH words, each GROUP_NB*KER_WIDTH bits: one kernel coefficient per processing group, packed.
- Write side: ready/valid loader that fills addresses 0..end, then stalls.
- Read side: an address-settable read pointer streams words to the compute array on each pop.

---
 rtl/kernel_memory_if.sv | 29 ++
 rtl/kernel_memory.sv | 95 +++++++++
 tb/tb_kernel_memory.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/kernel_memory_if.sv
// kernel_memory_if: loader and read-stream signals of the kernel weight buffer.
// The master modport is the controller side; the slave modport is the buffer.
interface kernel_memory_if #(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int MEM_AWIDTH = 8
);
    logic [MEM_AWIDTH-1:0]         wr_cfg_end;
    logic                          wr_cfg_set;
    logic [GROUP_NB*KER_WIDTH-1:0] wr_data;
    logic                          wr_data_val;
    logic                          wr_data_rdy;
    logic [MEM_AWIDTH-1:0]         rd_addr;
    logic                          rd_addr_set;
    logic [GROUP_NB*KER_WIDTH-1:0] rd_data;
    logic                          rd_data_pop;

    modport master (
        output wr_cfg_end, wr_cfg_set, wr_data, wr_data_val,
        output rd_addr, rd_addr_set, rd_data_pop,
        input  wr_data_rdy, rd_data
    );

    modport slave (
        input  wr_cfg_end, wr_cfg_set, wr_data, wr_data_val,
        input  rd_addr, rd_addr_set, rd_data_pop,
        output wr_data_rdy, rd_data
    );
endinterface

// File: rtl/kernel_memory.sv
// kernel_memory: kernel weight buffer for the CNN coprocessor.
// The loader fills addresses 0..wrEnd and then stalls; the read pointer
// streams one registered word per pop and wraps back to address 0.
// Build option KERNEL_MEM_RD_WRAP_EN: when defined, reads wrap at the
// configured write end address instead of at the last physical word.
module kernel_memory #(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int MEM_AWIDTH = 8,
    parameter int MEM_DEPTH  = 8
) (
    input logic           clk_i,
    input logic           rst_ni,
    kernel_memory_if.slave bus_io
);
    localparam int DW = GROUP_NB * KER_WIDTH;
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MEM_AWIDTH-1:0] LAST_ADDR = MEM_AWIDTH'(MEM_DEPTH - 1);

    logic [DW-1:0]         memArray [MEM_DEPTH];
    logic [MEM_AWIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [MEM_AWIDTH-1:0] wrEnd_q, wrEnd_d;
    logic                  wrFull_q, wrFull_d;
    logic                  wrRdy_q, wrRdy_d;
    logic                  wrAccept;
    logic [MEM_AWIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [MEM_AWIDTH-1:0] rdWrap;
    logic [DW-1:0]         rdData_q;

`ifdef KERNEL_MEM_RD_WRAP_EN
    assign rdWrap = wrEnd_q;
`else
    assign rdWrap = LAST_ADDR;
`endif

    // Write side: a config pulse restarts the load and wins over a same-cycle write.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        wrEnd_d  = wrEnd_q;
        wrFull_d = wrFull_q;
        wrAccept = 1'b0;
        if (bus_io.wr_cfg_set) begin
            wrEnd_d  = (bus_io.wr_cfg_end > LAST_ADDR) ? LAST_ADDR : bus_io.wr_cfg_end;
            wrPtr_d  = '0;
            wrFull_d = 1'b0;
        end else if (bus_io.wr_data_val && wrRdy_q) begin
            wrAccept = 1'b1;
            if (wrPtr_q == wrEnd_q) begin
                wrFull_d = 1'b1;
            end else begin
                wrPtr_d = wrPtr_q + MEM_AWIDTH'(1);
            end
        end
        wrRdy_d = !wrFull_d;
    end

    // Read pointer: an address load wins over a pop; pops wrap to 0 at the wrap point.
    always_comb begin
        rdPtr_d = rdPtr_q;
        if (bus_io.rd_addr_set) begin
            rdPtr_d = (bus_io.rd_addr > LAST_ADDR) ? LAST_ADDR : bus_io.rd_addr;
        end else if (bus_io.rd_data_pop) begin
            rdPtr_d = (rdPtr_q >= rdWrap) ? '0 : rdPtr_q + MEM_AWIDTH'(1);
        end
    end

    // Control state and the registered read word (sampled from pre-write memory).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q  <= '0;
            wrEnd_q  <= LAST_ADDR;
            wrFull_q <= 1'b0;
            wrRdy_q  <= 1'b0;
            rdPtr_q  <= '0;
            rdData_q <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            wrEnd_q  <= wrEnd_d;
            wrFull_q <= wrFull_d;
            wrRdy_q  <= wrRdy_d;
            rdPtr_q  <= rdPtr_d;
            rdData_q <= memArray[rdPtr_d[IW-1:0]];
        end
    end

    // Storage array, deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wrAccept) begin
            memArray[wrPtr_q[IW-1:0]] <= bus_io.wr_data;
        end
    end

    assign bus_io.wr_data_rdy = wrRdy_q;
    assign bus_io.rd_data     = rdData_q;
endmodule

// File: tb/tb_kernel_memory.sv
// tb_kernel_memory: directed vector table, hand sequences for the read
// stream and priority cases, then randomized traffic against a reference model.
module tb_kernel_memory;
    localparam int DEPTH = 8;

    logic clk;
    logic rstN;

    kernel_memory_if #(.GROUP_NB(4), .KER_WIDTH(16), .MEM_AWIDTH(8)) bus ();

    kernel_memory #(
        .GROUP_NB(4), .KER_WIDTH(16), .MEM_AWIDTH(8), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state
    logic [63:0] mMem [DEPTH];
    bit          mValid [DEPTH];
    int          mEnd, mNext, mRdPtr;
    bit          mFull, mRdy, mRdKnown;
    logic [63:0] mRdData;

    typedef struct {
        bit          cfgSet;
        logic [7:0]  cfgEnd;
        bit          val;
        logic [63:0] data;
        bit          expRdy;
        bit          chkData;
        logic [63:0] expData;
    } vec_t;

    vec_t vecs [22];

    task automatic modelReset();
        mEnd     = DEPTH - 1;
        mNext    = 0;
        mFull    = 1'b0;
        mRdy     = 1'b0;
        mRdPtr   = 0;
        mRdData  = '0;
        mRdKnown = 1'b1;
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, sample at edge+1.
    task automatic applyStimulus(input bit cfgSet, input logic [7:0] cfgEnd,
                                 input bit val, input logic [63:0] data,
                                 input bit addrSet, input logic [7:0] addr,
                                 input bit pop);
        int wrapPt;
        bus.wr_cfg_set  = cfgSet;
        bus.wr_cfg_end  = cfgEnd;
        bus.wr_data_val = val;
        bus.wr_data     = data;
        bus.rd_addr_set = addrSet;
        bus.rd_addr     = addr;
        bus.rd_data_pop = pop;
        @(posedge clk);
`ifdef KERNEL_MEM_RD_WRAP_EN
        wrapPt = mEnd;
`else
        wrapPt = DEPTH - 1;
`endif
        if (addrSet) mRdPtr = (int'(addr) > DEPTH - 1) ? DEPTH - 1 : int'(addr);
        else if (pop) mRdPtr = (mRdPtr >= wrapPt) ? 0 : mRdPtr + 1;
        mRdData  = mMem[mRdPtr];
        mRdKnown = mValid[mRdPtr];
        if (cfgSet) begin
            mEnd  = (int'(cfgEnd) > DEPTH - 1) ? DEPTH - 1 : int'(cfgEnd);
            mNext = 0;
            mFull = 1'b0;
        end else if (val && mRdy) begin
            mMem[mNext]   = data;
            mValid[mNext] = 1'b1;
            if (mNext == mEnd) mFull = 1'b1;
            else mNext++;
        end
        mRdy = !mFull;
        #1;
    endtask

    task automatic checkOutput(input string name, input bit expRdy,
                               input logic [63:0] expData, input bit chkData);
        bit ok;
        checkCount++;
        ok = (bus.wr_data_rdy === expRdy) && (!chkData || (bus.rd_data === expData));
        if (ok) passCount++;
        else $display("[TB] FAIL %s: rdy=%0b (want %0b) rd_data=%0h (want %0h, checked=%0b)",
                      name, bus.wr_data_rdy, expRdy, bus.rd_data, expData, chkData);
    endtask

    initial begin
        logic [63:0] expSeq [9];
        logic [63:0] expAfterPrio;

        for (int i = 0; i < DEPTH; i++) begin
            mValid[i] = 1'b0;
            mMem[i]   = '0;
        end
        modelReset();
        rstN = 1'b0;
        bus.wr_cfg_set = 0; bus.wr_cfg_end = 0; bus.wr_data_val = 0; bus.wr_data = 0;
        bus.rd_addr_set = 0; bus.rd_addr = 0; bus.rd_data_pop = 0;

        // Reset held for 6 cycles
        repeat (6) @(posedge clk);
        #1;
        checkOutput("reset_state", 1'b0, 64'd0, 1'b1);
        rstN = 1'b1;

        // Vector table: fill/overflow then reconfigure to a single word
        vecs[0] = '{0, 8'd0, 0, 64'd0, 1, 0, 64'd0};
        for (int k = 1; k <= 10; k++)
            vecs[k] = '{0, 8'd0, 1, 64'(k), (k < 8), (k >= 2), 64'd1};
        vecs[11] = '{1, 8'd0, 0, 64'd0, 1, 1, 64'd1};
        for (int k = 12; k <= 21; k++)
            vecs[k] = '{0, 8'd0, 1, 64'(k - 1), 0, 1, (k == 12) ? 64'd1 : 64'd11};

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].cfgSet, vecs[i].cfgEnd, vecs[i].val, vecs[i].data, 0, 8'd0, 0);
            checkOutput($sformatf("vec%0d", i), vecs[i].expRdy, vecs[i].expData, vecs[i].chkData);
        end

        // Read stream from address 0: set, one pop, then 7 continuous pops
`ifdef KERNEL_MEM_RD_WRAP_EN
        for (int i = 0; i < 9; i++) expSeq[i] = 64'd11;
        expAfterPrio = 64'd11;
`else
        expSeq[0] = 64'd11;
        for (int i = 1; i < 8; i++) expSeq[i] = 64'(i + 1);
        expSeq[8] = 64'd11;
        expAfterPrio = 64'd5;
`endif
        applyStimulus(0, 8'd0, 0, 64'd0, 1, 8'd0, 0);
        checkOutput("stream_set", 1'b0, expSeq[0], 1'b1);
        applyStimulus(0, 8'd0, 0, 64'd0, 0, 8'd0, 1);
        checkOutput("stream_pop1", 1'b0, expSeq[1], 1'b1);
        applyStimulus(0, 8'd0, 0, 64'd0, 0, 8'd0, 0);
        for (int i = 2; i < 9; i++) begin
            applyStimulus(0, 8'd0, 0, 64'd0, 0, 8'd0, 1);
            checkOutput($sformatf("stream_pop%0d", i), 1'b0, expSeq[i], 1'b1);
        end

        // Address set beats a simultaneous pop, then a pop from there
        applyStimulus(0, 8'd0, 0, 64'd0, 1, 8'd3, 1);
        checkOutput("prio_set_pop", 1'b0, 64'd4, 1'b1);
        applyStimulus(0, 8'd0, 0, 64'd0, 0, 8'd0, 1);
        checkOutput("pop_after_prio", 1'b0, expAfterPrio, 1'b1);

        // Out-of-range start address clamps to the last word
        applyStimulus(0, 8'd0, 0, 64'd0, 1, 8'd200, 0);
        checkOutput("addr_clamp", 1'b0, 64'd8, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit cs, v, as, p;
            logic [7:0] ce, ad;
            cs = ($urandom_range(0, 19) == 0);
            ce = 8'($urandom_range(0, 10));
            v  = ($urandom_range(0, 9) < 7);
            as = ($urandom_range(0, 7) == 0);
            ad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            p  = $urandom_range(0, 1) == 1;
            applyStimulus(cs, ce, v, {$urandom, $urandom}, as, ad, p);
            checkOutput($sformatf("rand%0d", i), mRdy, mRdData, mRdKnown);
        end

        // Reset asserted mid-cycle while streaming
        applyStimulus(0, 8'd0, 0, 64'd0, 0, 8'd0, 1);
        #3;
        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("midstream_reset", 1'b0, 64'd0, 1'b1);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(0, 8'd0, 0, 64'd0, 0, 8'd0, 0);
        checkOutput("post_reset_retained", mRdy, mRdData, mRdKnown);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
